// File: rtl/reservation_station.sv
// Eight-entry reservation station: dispatch capture, dual-CDB wakeup and
// in-order-by-index issue of the lowest ready entry to the execution unit.
module reservation_station (
    input  logic        clk,
    input  logic        rst,
    input  logic        dsp_valid,
    input  logic [5:0]  dsp_opnum,
    input  logic [31:0] dsp_imm,
    input  logic [31:0] dsp_pc,
    input  logic [3:0]  dsp_rob_tag,
    input  logic [31:0] dsp_V1,
    input  logic [31:0] dsp_V2,
    input  logic [3:0]  dsp_Q1,
    input  logic [3:0]  dsp_Q2,
    input  logic        dsp_Q1_rdy,
    input  logic        dsp_Q2_rdy,
    input  logic        alu_cdb_valid,
    input  logic [3:0]  alu_cdb_tag,
    input  logic [31:0] alu_cdb_data,
    input  logic        lsb_cdb_valid,
    input  logic [3:0]  lsb_cdb_tag,
    input  logic [31:0] lsb_cdb_data,
    input  logic        rollback_sign,
    output logic        full_sign,
    output logic        ex_valid,
    output logic [5:0]  opnum_to_ex,
    output logic [31:0] V1_to_ex,
    output logic [31:0] V2_to_ex,
    output logic [31:0] imm_to_ex,
    output logic [31:0] pc_to_ex,
    output logic [3:0]  rob_tag_to_ex
);

    localparam int unsigned NENT = 8;
    localparam int unsigned IDXW = 3;
    localparam int unsigned CNTW = 4;
    localparam int unsigned TAGW = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned OPW  = 6;

    typedef struct packed {
        logic            busy;
        logic [OPW-1:0]  opnum;
        logic [DW-1:0]   v1;
        logic [TAGW-1:0] q1;
        logic            q1_rdy;
        logic [DW-1:0]   v2;
        logic [TAGW-1:0] q2;
        logic            q2_rdy;
        logic [DW-1:0]   imm;
        logic [DW-1:0]   pc;
        logic [TAGW-1:0] rob_tag;
    } ent_t;

    ent_t r_ent [NENT];
    ent_t w_ent_nxt [NENT];
    ent_t w_sel;

    logic            w_free_vld;
    logic [IDXW-1:0] w_free_idx;
    logic            w_rdy_vld;
    logic [IDXW-1:0] w_rdy_idx;
    logic [CNTW-1:0] w_busy_cnt;

    logic            r_ex_valid;
    logic [OPW-1:0]  r_opnum;
    logic [DW-1:0]   r_v1;
    logic [DW-1:0]   r_v2;
    logic [DW-1:0]   r_imm;
    logic [DW-1:0]   r_pc;
    logic [TAGW-1:0] r_rob_tag;

    // Returns {ready, value} after snooping both result broadcasts.
    function automatic logic [DW:0] fwd(input logic rdy, input logic [TAGW-1:0] q,
                                        input logic [DW-1:0] v);
        if (!rdy && alu_cdb_valid && (q == alu_cdb_tag))
            fwd = {1'b1, alu_cdb_data};
        else if (!rdy && lsb_cdb_valid && (q == lsb_cdb_tag))
            fwd = {1'b1, lsb_cdb_data};
        else
            fwd = {rdy, v};
    endfunction

    // Lowest free entry, lowest ready entry and occupancy, all from stored state.
    always_comb begin
        w_free_vld = 1'b0;
        w_free_idx = '0;
        w_rdy_vld  = 1'b0;
        w_rdy_idx  = '0;
        w_busy_cnt = '0;
        for (int i = int'(NENT) - 1; i >= 0; i--) begin
            if (!r_ent[i].busy) begin
                w_free_vld = 1'b1;
                w_free_idx = IDXW'(i);
            end
            if (r_ent[i].busy && r_ent[i].q1_rdy && r_ent[i].q2_rdy) begin
                w_rdy_vld = 1'b1;
                w_rdy_idx = IDXW'(i);
            end
            w_busy_cnt = w_busy_cnt + CNTW'(r_ent[i].busy);
        end
    end

    assign w_sel = r_ent[w_rdy_idx];

    always_comb begin
        w_ent_nxt = r_ent;
        for (int i = 0; i < int'(NENT); i++) begin
            if (r_ent[i].busy) begin
                {w_ent_nxt[i].q1_rdy, w_ent_nxt[i].v1} = fwd(r_ent[i].q1_rdy, r_ent[i].q1, r_ent[i].v1);
                {w_ent_nxt[i].q2_rdy, w_ent_nxt[i].v2} = fwd(r_ent[i].q2_rdy, r_ent[i].q2, r_ent[i].v2);
            end
        end
        if (w_rdy_vld)
            w_ent_nxt[w_rdy_idx].busy = 1'b0;
        if (dsp_valid && w_free_vld) begin
            w_ent_nxt[w_free_idx].busy    = 1'b1;
            w_ent_nxt[w_free_idx].opnum   = dsp_opnum;
            w_ent_nxt[w_free_idx].q1      = dsp_Q1;
            w_ent_nxt[w_free_idx].q2      = dsp_Q2;
            w_ent_nxt[w_free_idx].imm     = dsp_imm;
            w_ent_nxt[w_free_idx].pc      = dsp_pc;
            w_ent_nxt[w_free_idx].rob_tag = dsp_rob_tag;
            {w_ent_nxt[w_free_idx].q1_rdy, w_ent_nxt[w_free_idx].v1} = fwd(dsp_Q1_rdy, dsp_Q1, dsp_V1);
            {w_ent_nxt[w_free_idx].q2_rdy, w_ent_nxt[w_free_idx].v2} = fwd(dsp_Q2_rdy, dsp_Q2, dsp_V2);
        end
        if (rollback_sign) begin
            for (int i = 0; i < int'(NENT); i++)
                w_ent_nxt[i].busy = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NENT); i++)
                r_ent[i] <= '0;
            r_ex_valid <= 1'b0;
            r_opnum    <= '0;
            r_v1       <= '0;
            r_v2       <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_rob_tag  <= '0;
        end else begin
            for (int i = 0; i < int'(NENT); i++)
                r_ent[i] <= w_ent_nxt[i];
            if (rollback_sign) begin
                r_ex_valid <= 1'b0;
            end else if (w_rdy_vld) begin
                r_ex_valid <= 1'b1;
                r_opnum    <= w_sel.opnum;
                r_v1       <= w_sel.v1;
                r_v2       <= w_sel.v2;
                r_imm      <= w_sel.imm;
                r_pc       <= w_sel.pc;
                r_rob_tag  <= w_sel.rob_tag;
            end else begin
                r_ex_valid <= 1'b0;
            end
        end
    end

    // Stall one entry early so the dispatcher's registered decision never overflows.
    assign full_sign     = (w_busy_cnt >= CNTW'(7));
    assign ex_valid      = r_ex_valid;
    assign opnum_to_ex   = r_opnum;
    assign V1_to_ex      = r_v1;
    assign V2_to_ex      = r_v2;
    assign imm_to_ex     = r_imm;
    assign pc_to_ex      = r_pc;
    assign rob_tag_to_ex = r_rob_tag;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed table, corner-case
// sequences and randomized traffic against a behavioural reference model.
module tb_reservation_station;

    logic        clk = 1'b0;
    logic        rst;
    logic        dsp_valid;
    logic [5:0]  dsp_opnum;
    logic [31:0] dsp_imm, dsp_pc, dsp_V1, dsp_V2;
    logic [3:0]  dsp_rob_tag, dsp_Q1, dsp_Q2;
    logic        dsp_Q1_rdy, dsp_Q2_rdy;
    logic        alu_cdb_valid, lsb_cdb_valid;
    logic [3:0]  alu_cdb_tag, lsb_cdb_tag;
    logic [31:0] alu_cdb_data, lsb_cdb_data;
    logic        rollback_sign;
    logic        full_sign, ex_valid;
    logic [5:0]  opnum_to_ex;
    logic [31:0] V1_to_ex, V2_to_ex, imm_to_ex, pc_to_ex;
    logic [3:0]  rob_tag_to_ex;

    reservation_station dut (
        .clk(clk), .rst(rst), .dsp_valid(dsp_valid), .dsp_opnum(dsp_opnum),
        .dsp_imm(dsp_imm), .dsp_pc(dsp_pc), .dsp_rob_tag(dsp_rob_tag),
        .dsp_V1(dsp_V1), .dsp_V2(dsp_V2), .dsp_Q1(dsp_Q1), .dsp_Q2(dsp_Q2),
        .dsp_Q1_rdy(dsp_Q1_rdy), .dsp_Q2_rdy(dsp_Q2_rdy),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_data(lsb_cdb_data),
        .rollback_sign(rollback_sign), .full_sign(full_sign), .ex_valid(ex_valid),
        .opnum_to_ex(opnum_to_ex), .V1_to_ex(V1_to_ex), .V2_to_ex(V2_to_ex),
        .imm_to_ex(imm_to_ex), .pc_to_ex(pc_to_ex), .rob_tag_to_ex(rob_tag_to_ex)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          dv;
        logic [5:0]  op;
        logic [31:0] imm, pc, v1, v2;
        logic [3:0]  tag, q1, q2;
        bit          r1, r2;
        bit          av;
        logic [3:0]  at;
        logic [31:0] ad;
        bit          lv;
        logic [3:0]  lt;
        logic [31:0] ld;
        bit          rb;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit          exv;
        logic [31:0] v1, v2;
        bit          full;
    } vec_t;

    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] v1, v2, imm, pc;
        logic [3:0]  q1, q2, tag;
        bit          r1, r2;
    } ment_t;

    ment_t       m [8];
    bit          m_exv;
    logic [5:0]  m_op;
    logic [31:0] m_v1, m_v2, m_imm, m_pc;
    logic [3:0]  m_tag;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t dsp(input logic [5:0] op, input logic [31:0] v1, input logic [3:0] q1,
                                  input bit r1, input logic [31:0] v2, input logic [3:0] q2,
                                  input bit r2, input logic [3:0] tag);
        stim_t s;
        s = idle();
        s.dv = 1'b1; s.op = op; s.v1 = v1; s.q1 = q1; s.r1 = r1;
        s.v2 = v2; s.q2 = q2; s.r2 = r2; s.tag = tag;
        s.imm = {26'h0, op} + 32'h100; s.pc = {28'h0, tag} << 2;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        dsp_valid = s.dv; dsp_opnum = s.op; dsp_imm = s.imm; dsp_pc = s.pc;
        dsp_rob_tag = s.tag; dsp_V1 = s.v1; dsp_V2 = s.v2; dsp_Q1 = s.q1; dsp_Q2 = s.q2;
        dsp_Q1_rdy = s.r1; dsp_Q2_rdy = s.r2;
        alu_cdb_valid = s.av; alu_cdb_tag = s.at; alu_cdb_data = s.ad;
        lsb_cdb_valid = s.lv; lsb_cdb_tag = s.lt; lsb_cdb_data = s.ld;
        rollback_sign = s.rb;
    endtask

    task automatic model_reset();
        foreach (m[i]) m[i] = '{default: '0};
        m_exv = 1'b0; m_op = '0; m_v1 = '0; m_v2 = '0; m_imm = '0; m_pc = '0; m_tag = '0;
    endtask

    task automatic snoop(input stim_t s, input bit r, input logic [3:0] q, input logic [31:0] v,
                         output bit ro, output logic [31:0] vo);
        ro = r; vo = v;
        if (!r && s.av && s.at == q) begin ro = 1'b1; vo = s.ad; end
        else if (!r && s.lv && s.lt == q) begin ro = 1'b1; vo = s.ld; end
    endtask

    // One clock edge of the reference behaviour, using pre-edge occupancy.
    task automatic model_step(input stim_t s);
        int fi = -1;
        int ri = -1;
        for (int i = 0; i < 8; i++) begin
            if (fi < 0 && !m[i].busy) fi = i;
            if (ri < 0 && m[i].busy && m[i].r1 && m[i].r2) ri = i;
        end
        if (s.rb) begin
            foreach (m[i]) m[i].busy = 1'b0;
            m_exv = 1'b0;
            return;
        end
        m_exv = (ri >= 0);
        if (ri >= 0) begin
            m_op = m[ri].op; m_v1 = m[ri].v1; m_v2 = m[ri].v2;
            m_imm = m[ri].imm; m_pc = m[ri].pc; m_tag = m[ri].tag;
            m[ri].busy = 1'b0;
        end
        foreach (m[i]) begin
            if (m[i].busy) begin
                snoop(s, m[i].r1, m[i].q1, m[i].v1, m[i].r1, m[i].v1);
                snoop(s, m[i].r2, m[i].q2, m[i].v2, m[i].r2, m[i].v2);
            end
        end
        if (s.dv && fi >= 0) begin
            m[fi].busy = 1'b1; m[fi].op = s.op; m[fi].imm = s.imm; m[fi].pc = s.pc;
            m[fi].tag = s.tag; m[fi].q1 = s.q1; m[fi].q2 = s.q2;
            snoop(s, s.r1, s.q1, s.v1, m[fi].r1, m[fi].v1);
            snoop(s, s.r2, s.q2, s.v2, m[fi].r2, m[fi].v2);
        end
    endtask

    task automatic check_model();
        int cnt = 0;
        foreach (m[i]) cnt += int'(m[i].busy);
        chk("model.ex_valid", 64'(ex_valid), 64'(m_exv));
        chk("model.full_sign", 64'(full_sign), 64'(cnt >= 7));
        chk("model.opnum", 64'(opnum_to_ex), 64'(m_op));
        chk("model.V1", 64'(V1_to_ex), 64'(m_v1));
        chk("model.V2", 64'(V2_to_ex), 64'(m_v2));
        chk("model.imm", 64'(imm_to_ex), 64'(m_imm));
        chk("model.pc", 64'(pc_to_ex), 64'(m_pc));
        chk("model.rob_tag", 64'(rob_tag_to_ex), 64'(m_tag));
    endtask

    task automatic step(input stim_t s);
        drive(s);
        @(posedge clk);
        model_step(s);
        #1;
        check_model();
    endtask

    vec_t  tbl [11];
    stim_t s;

    initial begin
        tbl[0]  = '{dsp(6'd3, 32'd5, 4'd0, 1, 32'd7, 4'd0, 1, 4'd1), 0, 32'd0, 32'd0, 0};
        tbl[1]  = '{idle(), 1, 32'd5, 32'd7, 0};
        tbl[2]  = '{idle(), 0, 32'd5, 32'd7, 0};
        tbl[3]  = '{dsp(6'd4, 32'd0, 4'd4, 0, 32'd2, 4'd0, 1, 4'd2), 0, 32'd5, 32'd7, 0};
        tbl[4]  = '{idle(), 0, 32'd5, 32'd7, 0};
        tbl[5]  = '{idle(), 0, 32'd5, 32'd7, 0};
        tbl[5].s.av = 1'b1; tbl[5].s.at = 4'd4; tbl[5].s.ad = 32'h10;
        tbl[6]  = '{idle(), 1, 32'h10, 32'd2, 0};
        tbl[7]  = '{idle(), 0, 32'h10, 32'd2, 0};
        tbl[8]  = '{dsp(6'd5, 32'd1, 4'd0, 1, 32'd0, 4'd9, 0, 4'd3), 0, 32'h10, 32'd2, 0};
        tbl[8].s.lv = 1'b1; tbl[8].s.lt = 4'd9; tbl[8].s.ld = 32'hAB;
        tbl[9]  = '{idle(), 1, 32'd1, 32'hAB, 0};
        tbl[10] = '{idle(), 0, 32'd1, 32'hAB, 0};

        rst = 1'b1;
        drive(idle());
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ex_valid", 64'(ex_valid), 64'd0);
        chk("reset.full_sign", 64'(full_sign), 64'd0);
        chk("reset.V1", 64'(V1_to_ex), 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 11; k++) begin
            step(tbl[k].s);
            chk($sformatf("tbl%0d.ex_valid", k), 64'(ex_valid), 64'(tbl[k].exv));
            chk($sformatf("tbl%0d.V1", k), 64'(V1_to_ex), 64'(tbl[k].v1));
            chk($sformatf("tbl%0d.V2", k), 64'(V2_to_ex), 64'(tbl[k].v2));
            chk($sformatf("tbl%0d.full", k), 64'(full_sign), 64'(tbl[k].full));
        end

        // Fill to capacity; the ninth (ready) dispatch must be dropped.
        for (int i = 0; i < 8; i++) begin
            step(dsp(6'd10, 32'd0, 4'd15, 0, 32'd3, 4'd0, 1, 4'(i)));
            chk($sformatf("fill%0d.full", i), 64'(full_sign), 64'(i >= 6));
        end
        step(dsp(6'd11, 32'd1, 4'd0, 1, 32'd1, 4'd0, 1, 4'd9));
        chk("fill9.full", 64'(full_sign), 64'd1);
        s = idle(); s.av = 1'b1; s.at = 4'd15; s.ad = 32'h5A5A;
        step(s);
        chk("drain.wake", 64'(ex_valid), 64'd0);
        for (int i = 0; i < 8; i++) begin
            step(idle());
            chk($sformatf("drain%0d.ex_valid", i), 64'(ex_valid), 64'd1);
            chk($sformatf("drain%0d.rob_tag", i), 64'(rob_tag_to_ex), 64'(i));
        end
        step(idle());
        chk("drain.end", 64'(ex_valid), 64'd0);

        // Entries 2 and 5 wake together; lower index issues first.
        for (int i = 0; i < 6; i++)
            step(dsp(6'd12, 32'd0, (i == 2 || i == 5) ? 4'd13 : 4'd14, 0, 32'd4, 4'd0, 1, 4'(i)));
        s = idle(); s.av = 1'b1; s.at = 4'd13; s.ad = 32'h1313;
        step(s);
        step(idle());
        chk("pri.first", 64'({ex_valid, rob_tag_to_ex}), 64'({1'b1, 4'd2}));
        step(idle());
        chk("pri.second", 64'({ex_valid, rob_tag_to_ex}), 64'({1'b1, 4'd5}));
        s = idle(); s.lv = 1'b1; s.lt = 4'd14; s.ld = 32'h1414;
        step(s);
        chk("pri.gap", 64'(ex_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(idle());
            chk($sformatf("pri.rest%0d", i), 64'(rob_tag_to_ex), 64'((i < 2) ? i : i + 1));
        end

        // Rollback with six busy plus a concurrent dispatch.
        for (int i = 0; i < 6; i++)
            step(dsp(6'd20, 32'd0, 4'd12, 0, 32'd4, 4'd0, 1, 4'(i)));
        s = dsp(6'd21, 32'd1, 4'd0, 1, 32'd2, 4'd0, 1, 4'd7);
        s.rb = 1'b1;
        step(s);
        chk("rb.ex_valid", 64'(ex_valid), 64'd0);
        chk("rb.full", 64'(full_sign), 64'd0);
        s = idle(); s.av = 1'b1; s.at = 4'd12; s.ad = 32'h1212;
        step(s);
        for (int i = 0; i < 3; i++) begin
            step(idle());
            chk($sformatf("rb.quiet%0d", i), 64'(ex_valid), 64'd0);
        end

        // Asynchronous reset while an issue is visible and another entry is busy.
        step(dsp(6'd30, 32'h33, 4'd0, 1, 32'h44, 4'd0, 1, 4'd1));
        step(dsp(6'd31, 32'h66, 4'd0, 1, 32'h67, 4'd0, 1, 4'd2));
        chk("arst.pre", 64'({ex_valid, V1_to_ex}), 64'({1'b1, 32'h33}));
        drive(idle());
        rst = 1'b1;
        #1;
        chk("arst.outs", 64'({ex_valid, full_sign, opnum_to_ex, rob_tag_to_ex, V1_to_ex}), 64'd0);
        chk("arst.data", 64'({V2_to_ex, pc_to_ex | imm_to_ex}), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(dsp(6'd32, 32'h77, 4'd0, 1, 32'h78, 4'd0, 1, 4'd3));
        step(idle());
        chk("arst.post", 64'({ex_valid, V1_to_ex}), 64'({1'b1, 32'h77}));
        step(idle());
        chk("arst.flushed", 64'(ex_valid), 64'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            s = idle();
            s.dv = ($urandom_range(0, 9) < 6);
            s.op = 6'($urandom); s.imm = $urandom; s.pc = $urandom; s.tag = 4'($urandom);
            s.v1 = $urandom; s.v2 = $urandom; s.q1 = 4'($urandom); s.q2 = 4'($urandom);
            s.r1 = $urandom_range(0, 1) == 1; s.r2 = $urandom_range(0, 1) == 1;
            s.av = $urandom_range(0, 1) == 1; s.at = 4'($urandom); s.ad = $urandom;
            s.lv = $urandom_range(0, 1) == 1; s.lt = 4'($urandom); s.ld = $urandom;
            if (s.av && s.lv && s.lt == s.at) s.lt = s.at + 4'd1;
            s.rb = ($urandom_range(0, 63) == 0);
            step(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port dsp_valid, input, 1 bit: dispatch request this cycle.
REQ-004 SHALL have ports dsp_opnum (6 bits), dsp_imm (32 bits), dsp_pc (32 bits) and dsp_rob_tag (4 bits), all inputs: the decoded instruction fields.
REQ-005 SHALL have ports dsp_V1 and dsp_V2 (32 bits), dsp_Q1 and dsp_Q2 (4 bits), and dsp_Q1_rdy and dsp_Q2_rdy (1 bit), all inputs: operand values, producer tags and ready flags.
REQ-006 SHALL have ports alu_cdb_valid (1 bit), alu_cdb_tag (4 bits) and alu_cdb_data (32 bits), all inputs: the ALU result broadcast.
REQ-007 SHALL have ports lsb_cdb_valid (1 bit), lsb_cdb_tag (4 bits) and lsb_cdb_data (32 bits), all inputs: the load/store buffer result broadcast.
REQ-008 SHALL have port rollback_sign, input, 1 bit: misprediction flush.
REQ-009 SHALL have port full_sign, output, 1 bit: tells the dispatcher to stall.
REQ-010 SHALL have port ex_valid, output, 1 bit: an issue to the execution unit is present.
REQ-011 SHALL have ports opnum_to_ex (6 bits), V1_to_ex, V2_to_ex, imm_to_ex and pc_to_ex (32 bits), and rob_tag_to_ex (4 bits), all outputs: the issued operation.

Function
REQ-012 SHALL hold 8 entries; each entry has busy, opnum, V1, Q1, Q1_rdy, V2, Q2, Q2_rdy, imm, pc and rob_tag.
REQ-013 SHALL, when dsp_valid is high and a free entry exists, write the dispatch into the lowest-index non-busy entry at the clock edge and set busy.
REQ-014 SHALL determine free entries from busy state at the start of the cycle, so an entry freed by issue on an edge is not reallocated on that same edge.
REQ-015 SHALL, for each valid CDB, set V to the CDB data and set Q_rdy on every busy entry operand whose Q_rdy is 0 and whose Q matches the CDB tag.
REQ-016 SHALL apply the same CDB match to the operands being dispatched in the same cycle, so the captured operand is ready with the CDB data.
REQ-017 SHALL apply both CDBs in the same cycle when both are valid; the two carry distinct tags.
REQ-018 SHALL treat an entry as ready when it is busy and both Q1_rdy and Q2_rdy are 1; readiness uses the stored state only, with no same-cycle wakeup-to-issue.
REQ-019 SHALL select the lowest-index ready entry each cycle, clear its busy flag at the edge, and register its fields into the *_to_ex outputs with ex_valid=1.
REQ-020 SHALL drive ex_valid=0 for one cycle after any cycle with no ready entry, and hold the *_to_ex data outputs unchanged in that case.
REQ-021 SHALL have latency as follows: a dispatch with both operands ready on edge t gives ex_valid during the cycle after edge t+1.
REQ-022 SHALL have latency as follows: a CDB wakeup in cycle N gives eligibility in cycle N+1 and ex_valid in cycle N+2.
REQ-023 SHALL drive full_sign combinationally, high when the busy count is 7 or more, to give one cycle of margin for the dispatcher's registered decision.
REQ-024 SHALL ignore dsp_valid when all 8 entries are busy: no entry changes.
REQ-025 SHALL, on rollback_sign=1 at an edge, clear all busy flags and ex_valid; rollback overrides any dispatch and issue in that cycle.
REQ-026 SHALL leave entries not selected, not allocated and not CDB-matched unchanged.

Reset
REQ-027 SHALL, while rst=1, immediately force all busy=0, ex_valid=0, all *_to_ex outputs to 0 and full_sign=0, regardless of clk.
REQ-028 SHALL discard an in-flight dispatch or issue when rst is asserted mid-operation, and SHALL accept dispatch from the first edge after rst is deasserted.

Verification
REQ-029 SHALL pass this scenario: dispatch opnum=3, V1=5, V2=7, both ready, on edge 1 -> ex_valid=1 during cycle 2, V1_to_ex=5, V2_to_ex=7, then ex_valid=0.
REQ-030 SHALL pass this scenario: dispatch with Q1=4 not ready, then alu_cdb tag=4 data=0x10 two cycles later -> issue two cycles after the CDB with V1_to_ex=0x10.
REQ-031 SHALL pass this scenario: dispatch with Q2=9 in the same cycle as lsb_cdb tag=9 data=0xAB -> issue with V2_to_ex=0xAB one cycle later, as for a ready dispatch.
REQ-032 SHALL pass this scenario: 7 dispatches of non-ready operations -> full_sign=1; an 8th dispatch is accepted; a 9th dispatch with 8 busy leaves the state unchanged.
REQ-033 SHALL pass this scenario: entries 2 and 5 become ready in the same cycle -> entry 2 issues first and entry 5 issues on the next cycle.
REQ-034 SHALL pass this scenario: rollback_sign with 6 busy entries plus a concurrent dispatch -> next cycle has 0 busy, full_sign=0 and ex_valid=0.
